// File: rtl/r_pow_exp_t.sv
// r^e for T packed GF(2^32) lanes via left-to-right square-and-multiply on one gf_mul_32.
// Define GF32_MUL_SHARED_EN to drive an external shared gf_mul_32 instead of an internal one.

module gf_mul_32 (
  input  logic        i_clk,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  input  logic        i_start,
  output logic [31:0] o_o,
  output logic        o_done
);

  // GF(2^8), x^8+x^4+x^3+x+1: carry-less product then reduction from the top bit down
  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ (15'(a) << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if (p[i]) p = p ^ (15'h11B << (i - 8));
    end
    return p[7:0];
  endfunction

  // X^2 = X + 0x20
  function automatic logic [15:0] gf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] hh;
    hh = gf8_mul(a[15:8], b[15:8]);
    return {hh ^ gf8_mul(a[15:8], b[7:0]) ^ gf8_mul(a[7:0], b[15:8]),
            gf8_mul(a[7:0], b[7:0]) ^ gf8_mul(hh, 8'h20)};
  endfunction

  // Y^2 = Y + 0x20*X
  function automatic logic [31:0] gf32_mul(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] hh;
    hh = gf16_mul(a[31:16], b[31:16]);
    return {hh ^ gf16_mul(a[31:16], b[15:0]) ^ gf16_mul(a[15:0], b[31:16]),
            gf16_mul(a[15:0], b[15:0]) ^ gf16_mul(hh, 16'h2000)};
  endfunction

  always_ff @(posedge i_clk) begin
    o_done <= i_start;
    if (i_start) o_o <= gf32_mul(i_x, i_y);
  end

endmodule

module r_pow_exp_t #(
  parameter string       FIELD         = "GF256",
  parameter string       PARAMETER_SET = "L1",
  parameter int unsigned M             = 230,
  parameter int unsigned T             = 3,
  localparam int unsigned W            = $clog2(M)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [32*T-1:0] i_r,
  input  logic [W-1:0]    i_exp,
  output logic [32*T-1:0] o_r_pow_exp,
  output logic            o_done
`ifdef GF32_MUL_SHARED_EN
  ,
  output logic            o_start_mul,
  output logic [31:0]     o_x_mul,
  output logic [31:0]     o_y_mul,
  input  logic [31:0]     o_o_mul,
  input  logic            i_done_mul
`endif
);

  localparam int unsigned LaneW = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned BitW  = (W > 1) ? $clog2(W) : 1;

  if (FIELD != "GF256") begin : g_bad_field
    $error("r_pow_exp_t: unsupported FIELD %s (%s)", FIELD, PARAMETER_SET);
  end

  typedef enum logic [1:0] {StIdle, StMulIssue, StMulWait, StDone} state_t;

  state_t            state_q, state_d;
  logic [32*T-1:0]   r_q, r_d;
  logic [W-1:0]      exp_q, exp_d;
  logic [LaneW-1:0]  lane_q, lane_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [31:0]       acc_q, acc_d;
  logic              sq_q, sq_d;
  logic [32*T-1:0]   res_q, res_d;
  logic              done_q, done_d;

  logic              mul_start;
  logic [31:0]       mul_x, mul_y, mul_prod;
  logic              mul_done;
  logic [31:0]       r_lane;

  assign r_lane    = r_q[32*lane_q +: 32];
  assign mul_start = (state_q == StMulIssue);
  assign mul_x     = acc_q;
  // sq_q selects squaring; otherwise multiply by the current lane operand
  assign mul_y     = sq_q ? acc_q : r_lane;

`ifdef GF32_MUL_SHARED_EN
  assign o_start_mul = mul_start;
  assign o_x_mul     = mul_x;
  assign o_y_mul     = mul_y;
  assign mul_prod    = o_o_mul;
  assign mul_done    = i_done_mul;
`else
  gf_mul_32 u_gf_mul_32 (
    .i_clk   (i_clk),
    .i_x     (mul_x),
    .i_y     (mul_y),
    .i_start (mul_start),
    .o_o     (mul_prod),
    .o_done  (mul_done)
  );
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    exp_d   = exp_q;
    lane_d  = lane_q;
    bit_d   = bit_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          r_d     = i_r;
          exp_d   = i_exp;
          lane_d  = '0;
          bit_d   = BitW'(W - 1);
          acc_d   = 32'h0000_0001;
          sq_d    = 1'b1;
          state_d = StMulIssue;
        end
      end
      StMulIssue: state_d = StMulWait;
      StMulWait: begin
        if (mul_done) begin
          acc_d   = mul_prod;
          state_d = StMulIssue;
          if (sq_q && exp_q[bit_q]) begin
            sq_d = 1'b0;
          end else begin
            sq_d = 1'b1;
            if (bit_q == '0) begin
              res_d[32*lane_q +: 32] = mul_prod;
              bit_d = BitW'(W - 1);
              acc_d = 32'h0000_0001;
              if (lane_q == LaneW'(T - 1)) state_d = StDone;
              else                         lane_d  = lane_q + 1'b1;
            end else begin
              bit_d = bit_q - 1'b1;
            end
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q    <= '0;
      exp_q  <= '0;
      lane_q <= '0;
      bit_q  <= '0;
      acc_q  <= '0;
      sq_q   <= 1'b0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      exp_q  <= exp_d;
      lane_q <= lane_d;
      bit_q  <= bit_d;
      acc_q  <= acc_d;
      sq_q   <= sq_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  assign o_r_pow_exp = res_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_r_pow_exp_t.sv
// Directed bench for r_pow_exp_t: vector table plus reset, busy-start and multiplier sequences.
// Build with GF32_MUL_SHARED_EN defined to exercise the external-multiplier configuration.

module tb_r_pow_exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [95:0] i_r;
  logic [7:0]  i_exp;
  logic [95:0] o_r_pow_exp;
  logic        o_done;

  logic [31:0] sa_x, sa_y, sa_o;
  logic        sa_start, sa_done;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

`ifdef GF32_MUL_SHARED_EN
  logic        o_start_mul;
  logic [31:0] o_x_mul, o_y_mul, o_o_mul;
  logic        i_done_mul;

  gf_mul_32 u_ext_mul (
    .i_clk   (i_clk),
    .i_x     (o_x_mul),
    .i_y     (o_y_mul),
    .i_start (o_start_mul),
    .o_o     (o_o_mul),
    .o_done  (i_done_mul)
  );
`endif

  r_pow_exp_t #(
    .FIELD         ("GF256"),
    .PARAMETER_SET ("L1"),
    .M             (230),
    .T             (3)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_r         (i_r),
    .i_exp       (i_exp),
    .o_r_pow_exp (o_r_pow_exp),
    .o_done      (o_done)
`ifdef GF32_MUL_SHARED_EN
    ,
    .o_start_mul (o_start_mul),
    .o_x_mul     (o_x_mul),
    .o_y_mul     (o_y_mul),
    .o_o_mul     (o_o_mul),
    .i_done_mul  (i_done_mul)
`endif
  );

  gf_mul_32 u_sa_mul (
    .i_clk   (i_clk),
    .i_x     (sa_x),
    .i_y     (sa_y),
    .i_start (sa_start),
    .o_o     (sa_o),
    .o_done  (sa_done)
  );

  // Reference field arithmetic: shift-and-xtime GF(2^8), tower built on top
  function automatic logic [7:0] m8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [15:0] m16(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] t;
    t = m8(a[15:8], b[15:8]);
    return {t ^ m8(a[15:8], b[7:0]) ^ m8(a[7:0], b[15:8]), m8(a[7:0], b[7:0]) ^ m8(8'h20, t)};
  endfunction

  function automatic logic [31:0] m32(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] t;
    t = m16(a[31:16], b[31:16]);
    return {t ^ m16(a[31:16], b[15:0]) ^ m16(a[15:0], b[31:16]),
            m16(a[15:0], b[15:0]) ^ m16(16'h2000, t)};
  endfunction

  // Plain repeated multiplication, independent of square-and-multiply ordering
  function automatic logic [95:0] pow3(input logic [95:0] r, input logic [7:0] e);
    logic [95:0] res;
    logic [31:0] acc;
    for (int k = 0; k < 3; k++) begin
      acc = 32'h0000_0001;
      for (int j = 0; j < int'(e); j++) acc = m32(acc, r[32*k +: 32]);
      res[32*k +: 32] = acc;
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Cycle 1 is the cycle right after the edge that samples i_start; n=-1 on timeout
  task automatic run(input logic [95:0] r, input logic [7:0] e, input int extra,
                     output int n, output logic [95:0] res);
    @(negedge i_clk);
    i_r     = r;
    i_exp   = e;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    n = 1;
    while (!o_done && n < 400) begin
      if (n == extra) begin
        i_start = 1'b1;
        i_exp   = 8'h00;
        i_r     = ~r;
      end
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      n++;
    end
    res = o_r_pow_exp;
    if (!o_done) n = -1;
  endtask

  typedef struct {
    logic [95:0] r;
    logic [7:0]  e;
    logic [95:0] exp;
    int          lat;
    int          extra;
  } vec_t;

  localparam logic [95:0] R1   = {32'h1234_5678, 32'h3322_3322, 32'h2222_2222};
  localparam logic [95:0] R2   = {32'h1234_5678, 32'h0000_0000, 32'hDEAD_BEEF};
  localparam logic [95:0] ONES = {32'h1, 32'h1, 32'h1};

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t        vecs [8];
    int          n;
    logic [95:0] res;
    logic        seen;

    vecs[0] = '{R1, 8'h87, pow3(R1, 8'h87), 74, 0};
    vecs[1] = '{R1, 8'h01, R1,              56, 0};
    vecs[2] = '{R1, 8'h00, ONES,            50, 0};
    vecs[3] = '{R1, 8'h02, {m32(R1[95:64], R1[95:64]), m32(R1[63:32], R1[63:32]),
                            m32(R1[31:0], R1[31:0])}, 56, 0};
    vecs[4] = '{R2, 8'h87, pow3(R2, 8'h87), 74, 0};
    vecs[5] = '{R2, 8'h00, ONES,            50, 0};
    vecs[6] = '{R2, 8'hFF, pow3(R2, 8'hFF), 98, 0};
    vecs[7] = '{R1, 8'h87, pow3(R1, 8'h87), 74, 10};

    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_r      = '0;
    i_exp    = '0;
    sa_x     = '0;
    sa_y     = '0;
    sa_start = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("reset_result", o_r_pow_exp, '0);
    chk("reset_done", 96'(o_done), 96'(0));
`ifdef GF32_MUL_SHARED_EN
    chk("reset_start_mul", 96'(o_start_mul), 96'(0));
    chk("reset_xy_mul", {32'h0, o_x_mul, o_y_mul}, '0);
`endif

    // Standalone multiplier: hand-derived tower products and one-cycle done
    begin
      logic [95:0] sa_vec [3];
      sa_vec[0] = {32'h0000_0100, 32'h0000_0100, 32'h0000_0120};
      sa_vec[1] = {32'h0001_0000, 32'h0001_0000, 32'h0001_2000};
      sa_vec[2] = {32'h0000_0001, 32'h1234_5678, 32'h1234_5678};
      for (int i = 0; i < 3; i++) begin
        @(negedge i_clk);
        sa_x     = sa_vec[i][95:64];
        sa_y     = sa_vec[i][63:32];
        sa_start = 1'b1;
        @(posedge i_clk);
        #1;
        sa_start = 1'b0;
        chk($sformatf("mul_product_%0d", i), 96'(sa_o), 96'(sa_vec[i][31:0]));
        chk($sformatf("mul_done_%0d", i), 96'(sa_done), 96'(1));
      end
      @(posedge i_clk);
      #1;
      chk("mul_done_pulse", 96'(sa_done), 96'(0));
    end

    for (int i = 0; i < 8; i++) begin
      run(vecs[i].r, vecs[i].e, vecs[i].extra, n, res);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 96'(n), 96'(vecs[i].lat));
      @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), 96'(o_done), 96'(0));
      repeat (3) @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d_hold", i), o_r_pow_exp, vecs[i].exp);
    end

    // Reset in the middle of a run: immediate clear, no done, then a clean restart
    @(negedge i_clk);
    i_r     = R2;
    i_exp   = 8'h87;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (19) begin
      @(posedge i_clk);
      #1;
    end
    i_rst = 1'b1;
    #1;
    chk("midreset_result", o_r_pow_exp, '0);
    chk("midreset_done", 96'(o_done), 96'(0));
`ifdef GF32_MUL_SHARED_EN
    chk("midreset_start_mul", 96'(o_start_mul), 96'(0));
`endif
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    seen  = 1'b0;
    repeat (100) begin
      @(posedge i_clk);
      #1;
      if (o_done) seen = 1'b1;
    end
    chk("midreset_no_done", 96'(seen), 96'(0));
    chk("midreset_idle_result", o_r_pow_exp, '0);
    run(R2, 8'h87, 0, n, res);
    chk("restart_result", res, pow3(R2, 8'h87));
    chk("restart_latency", 96'(n), 96'(74));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/r_pow_exp_t.md
# r_pow_exp_t

Computes, for T independent GF(2^32) elements packed in one bus, each element raised to a common unsigned exponent (r_k^e), using left-to-right square-and-multiply on one GF(2^32) multiplier (`gf_mul_32`). It serves the SDitH (GF256 variant) challenge-power path. Lanes are processed serially. The multiplier is either instantiated internally or borrowed from a shared external instance.

## Interface
- FIELD, "GF256", field variant; only "GF256" is supported.
- PARAMETER_SET, "L1", security level tag; no functional effect.
- M, 230, exponent bound; W = clog2(M) is the exponent width (8 by default).
- T, 3, number of 32-bit lanes.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle start pulse.
- i_r  in  32*T  operands; lane k is bits [32k+31:32k].
- i_exp  in  W  exponent e.
- o_r_pow_exp  out  32*T  results, lane-aligned with i_r.
- o_done  out  1  one-cycle completion pulse.
- Shared-multiplier ports (GF32_MUL_SHARED_EN only):
  - o_start_mul  out  1
  - o_x_mul  out  32
  - o_y_mul  out  32
  - o_o_mul  in  32  product input; the codebase name is kept.
  - i_done_mul  in  1

## Operation
- GF(2^32) tower:
  - GF(2^8) reduction polynomial is x^8+x^4+x^3+x+1.
  - GF(2^16) = GF(2^8)[X]/(X^2+X+0x20); bits [7:0] hold the constant coefficient, bits [15:8] the X coefficient.
  - GF(2^32) = GF(2^16)[Y]/(Y^2+Y+0x20·X); bits [15:0] hold the constant coefficient, bits [31:16] the Y coefficient.
- gf_mul_32:
  - Ports: i_clk, i_x, i_y, i_start, o_o, o_done.
  - The product is computed combinationally and registered into o_o on the edge that samples i_start.
  - o_done pulses the following cycle.
- States: IDLE, MUL_ISSUE, MUL_WAIT, DONE.
- On i_start in IDLE:
  - Latch i_r and i_exp.
  - Set lane=0, bit=W-1, acc=0x00000001.
  - Go to MUL_ISSUE for a squaring.
- Per bit, MSB first:
  - Square: acc=acc·acc.
  - If exp[bit]=1, multiply: acc=acc·r_lane.
  - Every bit is processed, including leading zeros.
- After bit 0:
  - Write acc into lane `lane` of the result register.
  - Advance to the next lane with acc reset to 1.
  - After lane T-1, go to DONE.
- DONE pulses o_done for one cycle, then returns to IDLE.
- o_r_pow_exp holds its value until the next run overwrites it lane by lane.
- i_start while not IDLE is ignored.
- e=0 yields 0x00000001 in every lane, including r=0.

## Timing
- Each multiplication takes exactly 2 cycles: MUL_ISSUE asserts the multiplier start, MUL_WAIT captures the product on done.
- Latency: o_done goes high exactly 2·T·(W+popcount(e))+2 cycles after the edge that samples i_start.
  - e=0x87, T=3, W=8: 74 cycles.
- With GF32_MUL_SHARED_EN, MUL_WAIT waits for i_done_mul.
  - The latency above holds for a 1-cycle external multiplier and stretches otherwise.
- Reset values: o_done=0, o_r_pow_exp=0, state=IDLE, o_start_mul=0, o_x_mul=0, o_y_mul=0.
- Reset mid-operation aborts immediately to those values; no o_done pulse is produced.

## Configuration
- GF32_MUL_SHARED_EN defined:
  - No internal gf_mul_32 is instantiated.
  - The shared-multiplier ports exist and drive an external gf_mul_32.
  - o_x_mul/o_y_mul hold the operands while o_start_mul pulses.
- GF32_MUL_SHARED_EN undefined:
  - Those ports are absent.
  - One internal gf_mul_32 is instantiated.
- Results are identical either way.

## Test plan
- gf_mul_32 standalone:
  - 0x00000100·0x00000100 -> 0x00000120.
  - 0x00010000·0x00010000 -> 0x00012000.
  - 0x00000001·0x12345678 -> 0x12345678.
  - o_done one cycle after i_start.
- i_r={0x12345678,0x33223322,0x22222222}, i_exp=0x87 -> each lane equals the software reference r^135; o_done at cycle 74.
- Same i_r, i_exp=0x01 -> o_r_pow_exp equals i_r; o_done at cycle 56.
- i_exp=0x00 -> every lane 0x00000001; o_done at cycle 50.
- i_exp=0x02 -> each lane equals standalone gf_mul_32(r,r); i_r lane=0 with i_exp=0x87 -> that lane 0.
- Reset asserted at cycle 20 of a run:
  - Outputs go to 0; no o_done.
  - A new start then completes normally.
- Repeat every scenario with GF32_MUL_SHARED_EN defined and an external gf_mul_32 attached.
